// File: rtl/akp_line_sequencer_pkg.sv
// Shared AKP definitions: sequencer state encoding, default widths and the
// per-word framing tag carried alongside the datapath latency.
package akp_line_sequencer_pkg;

  localparam int CNT_W_DEF    = 12;
  localparam int PIPE_LAT_DEF = 3;
  localparam int PIPE_LAT_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_KSI = 2'd1,
    ST_READ     = 2'd2,
    ST_DRAIN    = 2'd3
  } akp_state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } akp_tag_t;

  // Builds the tag for one FIFO read slot; idle slots carry no framing.
  function automatic akp_tag_t make_tag(input logic rd, input logic first,
                                        input logic last);
    akp_tag_t t;
    t.valid = rd;
    t.first = rd & first;
    t.last  = rd & last;
    return t;
  endfunction

endpackage

// File: rtl/akp_tag_delay.sv
// Fixed-depth shift register with synchronous clear; aligns side-band tags
// with a datapath of known latency (line framing, PEL alignment).
module akp_tag_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/akp_line_sequencer.sv
// Per-line FIFO read-out controller: issues L_stroke+1 reads after the
// coefficients are ready and frames the delayed output words.
module akp_line_sequencer
  import akp_line_sequencer_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic             clk,
  input  logic             sbros_n,
  input  logic             ink_i,
  input  logic             ksi_en,
  input  logic [CNT_W-1:0] L_stroke,
  input  logic             fifo_empty,
  output logic             read_fifo,
  output logic             data_valid,
  output logic             sop,
  output logic             eop,
  output logic             line_done,
  output logic             line_abort,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt
);

  if (PIPE_LAT < 1 || PIPE_LAT > PIPE_LAT_MAX) begin : g_lat_check
    $error("akp_line_sequencer: PIPE_LAT out of range 1..8");
  end

  localparam logic [3:0] DRAIN_LAST = 4'(PIPE_LAT - 1);

  akp_state_e       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       drain_q, drain_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             rd;
  logic             is_first;
  logic             is_last;
  logic             tag_clr;
  akp_tag_t         tag_in;
  akp_tag_t         tag_out;

  assign rd       = (state_q == ST_READ) && !fifo_empty;
  assign is_first = (cnt_q == '0);
  // Compared before the increment so a full 2^CNT_W line never wraps early.
  assign is_last  = (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    tag_clr = 1'b0;

    if (ink_i) begin
      // A new line always restarts; anything in flight is abandoned.
      if (state_q != ST_IDLE) begin
        abort_d = 1'b1;
        tag_clr = 1'b1;
      end
      len_d   = L_stroke;
      cnt_d   = '0;
      drain_d = '0;
      state_d = ST_WAIT_KSI;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_WAIT_KSI: begin
          if (ksi_en) state_d = ST_READ;
        end
        ST_READ: begin
          if (rd) begin
            cnt_d = cnt_q + 1'b1;
            if (is_last) begin
              state_d = ST_DRAIN;
              drain_d = '0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            drain_d = drain_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge sbros_n) begin
    if (!sbros_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign tag_in = make_tag(rd, is_first, is_last);

  akp_tag_delay #(
    .WIDTH($bits(akp_tag_t)),
    .DEPTH(PIPE_LAT)
  ) u_tag_delay (
    .clk_i (clk),
    .rst_ni(sbros_n),
    .clr_i (tag_clr),
    .din_i (tag_in),
    .dout_o(tag_out)
  );

  assign read_fifo  = rd;
  assign data_valid = tag_out.valid;
  assign sop        = tag_out.first;
  assign eop        = tag_out.last;
  assign line_done  = done_q;
  assign line_abort = abort_q;
  assign busy       = (state_q != ST_IDLE);
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_akp_line_sequencer.sv
// Bench for akp_line_sequencer: directed table, corner sequences and random
// stimulus against a schedule-based reference model.
module tb_akp_line_sequencer;

  localparam int CNT_W    = 12;
  localparam int PIPE_LAT = 3;
  localparam int RING     = 16;
  localparam int CNT_MOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             sbros_n;
  logic             ink_i, ksi_en, fifo_empty;
  logic [CNT_W-1:0] L_stroke;
  logic             read_fifo, data_valid, sop, eop, line_done, line_abort, busy;
  logic [CNT_W-1:0] sample_cnt;

  always #5 clk = ~clk;

  akp_line_sequencer #(.CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk       (clk),
    .sbros_n   (sbros_n),
    .ink_i     (ink_i),
    .ksi_en    (ksi_en),
    .L_stroke  (L_stroke),
    .fifo_empty(fifo_empty),
    .read_fifo (read_fifo),
    .data_valid(data_valid),
    .sop       (sop),
    .eop       (eop),
    .line_done (line_done),
    .line_abort(line_abort),
    .busy      (busy),
    .sample_cnt(sample_cnt)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: line phase plus a time-indexed schedule of output events.
  // phase 0 idle, 1 waiting for coefficients, 2 reading, 3 draining.
  int m_phase, m_len, m_cnt, m_done_at;
  bit m_abort;
  bit s_dv[RING], s_sop[RING], s_eop[RING], s_done[RING];

  bit o_rd, o_dv, o_sop, o_eop, o_done, o_abort, o_busy;
  int o_cnt;
  int rd_cnt, dv_cnt, sop_cnt, eop_cnt, done_cnt, abort_cnt;
  int first_rd, first_dv, sop_at, eop_at, done_at;

  typedef struct {
    bit ink, ksi, fe;
    int L;
    bit rd, dv, sop, eop, done, busy;
    int cnt;
  } vec_t;
  vec_t tv[11];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < RING; i++) begin
      s_dv[i] = 0; s_sop[i] = 0; s_eop[i] = 0; s_done[i] = 0;
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_len = 0; m_cnt = 0; m_done_at = -1; m_abort = 0;
    clear_sched();
  endtask

  task automatic clr_stats();
    rd_cnt = 0; dv_cnt = 0; sop_cnt = 0; eop_cnt = 0; done_cnt = 0; abort_cnt = 0;
    first_rd = -1; first_dv = -1; sop_at = -1; eop_at = -1; done_at = -1;
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model.
  task automatic cyc1(input bit ink, input bit ksi, input bit fe, input int L);
    int s, t;
    ink_i = ink; ksi_en = ksi; fifo_empty = fe; L_stroke = CNT_W'(L);
    @(negedge clk);
    s = cyc % RING;
    if (m_phase == 3 && cyc == m_done_at) m_phase = 0;
    o_rd = read_fifo; o_dv = data_valid; o_sop = sop; o_eop = eop;
    o_done = line_done; o_abort = line_abort; o_busy = busy; o_cnt = int'(sample_cnt);
    chk("busy",       int'(o_busy),  int'(m_phase != 0));
    chk("read_fifo",  int'(o_rd),    int'(m_phase == 2 && !fe));
    chk("sample_cnt", o_cnt,         m_cnt % CNT_MOD);
    chk("data_valid", int'(o_dv),    int'(s_dv[s]));
    chk("sop",        int'(o_sop),   int'(s_sop[s]));
    chk("eop",        int'(o_eop),   int'(s_eop[s]));
    chk("line_done",  int'(o_done),  int'(s_done[s]));
    chk("line_abort", int'(o_abort), int'(m_abort));
    if (o_rd) begin rd_cnt++; if (first_rd < 0) first_rd = cyc; end
    if (o_dv) begin dv_cnt++; if (first_dv < 0) first_dv = cyc; end
    if (o_sop) begin sop_cnt++; sop_at = cyc; end
    if (o_eop) begin eop_cnt++; eop_at = cyc; end
    if (o_done) begin done_cnt++; done_at = cyc; end
    if (o_abort) abort_cnt++;
    s_dv[s] = 0; s_sop[s] = 0; s_eop[s] = 0; s_done[s] = 0;
    m_abort = 0;
    if (ink) begin
      if (m_phase != 0) begin
        m_abort = 1;
        clear_sched();
      end
      m_phase = 1; m_len = L; m_cnt = 0;
    end else if (m_phase == 1 && ksi) begin
      m_phase = 2;
    end else if (m_phase == 2 && !fe) begin
      t = (cyc + PIPE_LAT) % RING;
      s_dv[t] = 1; s_sop[t] = (m_cnt == 0); s_eop[t] = (m_cnt == m_len);
      if (m_cnt == m_len) begin
        m_phase = 3;
        m_done_at = cyc + PIPE_LAT + 1;
        s_done[m_done_at % RING] = 1;
      end
      m_cnt++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    // L_stroke=1 line with a one-cycle stall between the two reads
    tv[0]  = '{1,0,0,1, 0,0,0,0,0,0, 0};
    tv[1]  = '{0,0,0,0, 0,0,0,0,0,1, 0};
    tv[2]  = '{0,1,0,0, 0,0,0,0,0,1, 0};
    tv[3]  = '{0,0,0,0, 1,0,0,0,0,1, 0};
    tv[4]  = '{0,0,1,0, 0,0,0,0,0,1, 1};
    tv[5]  = '{0,0,0,0, 1,0,0,0,0,1, 1};
    tv[6]  = '{0,0,0,0, 0,1,1,0,0,1, 2};
    tv[7]  = '{0,0,0,0, 0,0,0,0,0,1, 2};
    tv[8]  = '{0,0,0,0, 0,1,0,1,0,1, 2};
    tv[9]  = '{0,0,0,0, 0,0,0,0,1,0, 2};
    tv[10] = '{0,0,0,0, 0,0,0,0,0,0, 2};

    sbros_n = 1'b0; ink_i = 0; ksi_en = 0; fifo_empty = 0; L_stroke = '0;
    clr_stats();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",       int'(busy),       0);
    chk("rst_read_fifo",  int'(read_fifo),  0);
    chk("rst_data_valid", int'(data_valid), 0);
    chk("rst_sop_eop",    int'({sop, eop}), 0);
    chk("rst_done_abort", int'({line_done, line_abort}), 0);
    chk("rst_sample_cnt", int'(sample_cnt), 0);
    @(negedge clk) sbros_n = 1'b1;
    @(posedge clk); #1;
    model_reset();

    for (int i = 0; i < 11; i++) begin
      cyc1(tv[i].ink, tv[i].ksi, tv[i].fe, tv[i].L);
      chk("tv_read_fifo",  int'(o_rd),   int'(tv[i].rd));
      chk("tv_data_valid", int'(o_dv),   int'(tv[i].dv));
      chk("tv_sop",        int'(o_sop),  int'(tv[i].sop));
      chk("tv_eop",        int'(o_eop),  int'(tv[i].eop));
      chk("tv_line_done",  int'(o_done), int'(tv[i].done));
      chk("tv_busy",       int'(o_busy), int'(tv[i].busy));
      chk("tv_sample_cnt", o_cnt,        tv[i].cnt);
    end

    // Eight-word line, coefficients two cycles after the strobe
    clr_stats();
    cyc1(1, 0, 0, 7); cyc1(0, 0, 0, 0); cyc1(0, 1, 0, 0);
    repeat (16) cyc1(0, 0, 0, 0);
    chk("l7_reads", rd_cnt, 8);
    chk("l7_words", dv_cnt, 8);
    chk("l7_latency", first_dv - first_rd, PIPE_LAT);
    chk("l7_sop_first", sop_at, first_dv);
    chk("l7_eop_pos", eop_at - first_dv, 7);
    chk("l7_done_after_eop", done_at - eop_at, 1);

    // Single-sample line
    clr_stats();
    cyc1(1, 0, 0, 0); cyc1(0, 1, 0, 0);
    repeat (8) cyc1(0, 0, 0, 0);
    chk("l0_reads", rd_cnt, 1);
    chk("l0_words", dv_cnt, 1);
    chk("l0_sop_eop_same", int'(sop_at == eop_at && sop_cnt == 1 && eop_cnt == 1), 1);

    // Two-cycle FIFO stall after the second read
    clr_stats();
    cyc1(1, 0, 0, 4); cyc1(0, 1, 0, 0);
    cyc1(0, 0, 0, 0); cyc1(0, 0, 0, 0); cyc1(0, 0, 1, 0); cyc1(0, 0, 1, 0);
    repeat (10) cyc1(0, 0, 0, 0);
    chk("stall_reads", rd_cnt, 5);
    chk("stall_words", dv_cnt, 5);
    chk("stall_eop_count", eop_cnt, 1);
    chk("stall_eop_span", eop_at - first_dv, 6);

    // New line arrives after four reads of a ten-sample line
    clr_stats();
    cyc1(1, 0, 0, 9); cyc1(0, 1, 0, 0);
    repeat (4) cyc1(0, 0, 0, 0);
    cyc1(1, 0, 0, 2);
    chk("abort_reads", rd_cnt, 5);
    clr_stats();
    repeat (5) cyc1(0, 0, 0, 0);
    chk("abort_pulse", abort_cnt, 1);
    chk("abort_words_flushed", dv_cnt, 0);
    chk("abort_no_eop_done", eop_cnt + done_cnt, 0);
    chk("abort_waiting", int'(o_busy), 1);
    clr_stats();
    cyc1(0, 1, 0, 0);
    repeat (10) cyc1(0, 0, 0, 0);
    chk("abort_next_reads", rd_cnt, 3);
    chk("abort_next_words", dv_cnt, 3);
    chk("abort_next_done", done_cnt, 1);

    // Coefficient pulses outside WAIT_KSI
    clr_stats();
    cyc1(0, 1, 0, 0);
    cyc1(1, 1, 0, 5);
    repeat (3) cyc1(0, 0, 0, 0);
    chk("ksi_idle_ignored", rd_cnt, 0);
    chk("ksi_still_waiting", int'(o_busy), 1);
    cyc1(0, 1, 0, 0);
    for (int i = 0; i < 14; i++) cyc1(0, bit'(i % 2), 0, 0);
    chk("ksi_read_ignored", rd_cnt, 6);
    chk("ksi_one_eop", eop_cnt, 1);

    // Longest legal line: the last-read compare happens before the wrap
    clr_stats();
    cyc1(1, 0, 0, CNT_MOD - 1); cyc1(0, 1, 0, 0);
    repeat (CNT_MOD + 4) cyc1(0, 0, 0, 0);
    chk("max_reads", rd_cnt, CNT_MOD);
    chk("max_words", dv_cnt, CNT_MOD);
    chk("max_framing", sop_cnt * 10 + eop_cnt, 11);
    chk("max_done", done_cnt, 1);

    // Asynchronous reset in the middle of a line
    clr_stats();
    cyc1(1, 0, 0, 20); cyc1(0, 1, 0, 0);
    repeat (5) cyc1(0, 0, 0, 0);
    #2 sbros_n = 1'b0;
    #1;
    chk("arst_read_fifo",  int'(read_fifo),  0);
    chk("arst_data_valid", int'(data_valid), 0);
    chk("arst_busy",       int'(busy),       0);
    chk("arst_flags", int'({sop, eop, line_done, line_abort}), 0);
    chk("arst_sample_cnt", int'(sample_cnt), 0);
    @(negedge clk);
    @(negedge clk) sbros_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    clr_stats();
    repeat (10) cyc1(0, 0, 0, 0);
    chk("arst_no_spurious", rd_cnt + dv_cnt, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc1(bit'($urandom_range(0, 39) == 0), bit'($urandom_range(0, 3) == 0),
           bit'($urandom_range(0, 3) == 0), int'($urandom_range(0, 12)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/akp_line_sequencer.md
# akp_line_sequencer

Per-line read-out controller for the AKP adaptive-compensation channel. It accepts the line strobe (`ink_i`) and the coefficient-ready pulse (`ksi_en`) from the KSI calculator, then issues exactly `L_stroke+1` read strobes to the input sample FIFO, stalling while it is empty. It delays those strobes through the datapath latency to produce aligned `data_valid`/`sop`/`eop` framing for the 192-bit output word. A new line arriving mid-read aborts the current line cleanly.

## Interface
- `CNT_W`, 12: width of sample counter and `L_stroke`.
- `PIPE_LAT`, 3: cycles from a `read_fifo` strobe to the matching output word (range 1..8).
- `clk`  in  1  system clock; all logic on rising edge.
- `sbros_n`  in  1  reset, asynchronous, active-low.
- `ink_i`  in  1  line-start strobe, one-cycle pulse.
- `ksi_en`  in  1  coefficients for current line ready, one-cycle pulse.
- `L_stroke`  in  CNT_W  index of last sample in line; sampled on `ink_i`.
- `fifo_empty`  in  1  sample FIFO empty.
- `read_fifo`  out  1  FIFO read strobe (combinational from state and `fifo_empty`).
- `data_valid`  out  1  output word valid.
- `sop`  out  1  first word of line, coincident with its `data_valid`.
- `eop`  out  1  last word of line, coincident with its `data_valid`.
- `line_done`  out  1  one-cycle pulse after the last word leaves the pipeline.
- `line_abort`  out  1  one-cycle pulse when a line is abandoned.
- `busy`  out  1  state ≠ IDLE.
- `sample_cnt`  out  CNT_W  number of reads issued in the current line.

## Operation
- States: IDLE, WAIT_KSI, READ, DRAIN.
- IDLE: on `ink_i`, latch `L_stroke` into `len_q`, clear `sample_cnt`, and go to WAIT_KSI. `ksi_en` is ignored in this state.
- WAIT_KSI: on `ksi_en`, go to READ.
- READ: `read_fifo = ~fifo_empty`. Each strobe increments `sample_cnt`. The strobe issued when `sample_cnt == len_q` is the last one; the next state is DRAIN.
- DRAIN: hold for `PIPE_LAT` cycles (`read_fifo=0`), pulse `line_done`, then return to IDLE.
- Tag pipeline: a `PIPE_LAT`-deep shift register of {valid, first, last}, where first = (`sample_cnt==0`) and last = (`sample_cnt==len_q`) at strobe time. Its outputs drive `data_valid`, `sop`, and `eop` directly.
- `ink_i` in any state other than IDLE:
  - pulse `line_abort`;
  - clear the tag pipeline in the same edge;
  - latch the new `L_stroke`, clear `sample_cnt`, and go to WAIT_KSI.
  - No `eop` or `line_done` is produced for the aborted line.
- `ink_i` in the same cycle as the last read: the abort wins. The FIFO read still occurs, but its tag is discarded.
- `ksi_en` outside WAIT_KSI is ignored. A `ksi_en` coincident with `ink_i` in IDLE is also ignored; the block waits for the next `ksi_en`.
- `L_stroke=0` gives a one-sample line, with `sop` and `eop` on the same word.
- Counter arithmetic is unsigned CNT_W. `len_q = 2^CNT_W−1` is legal, and the last-read compare occurs before any wrap.
- Reset: state IDLE; all outputs and the tag pipeline 0; `len_q`=0.

## Timing
- `ink_i` at edge t → `busy`=1 from t+1.
- `ksi_en` at edge t (in WAIT_KSI) → first possible `read_fifo` in cycle t+1.
- `read_fifo` in cycle c → matching `data_valid` in cycle c+`PIPE_LAT`.
- Throughput is 1 word/cycle with the FIFO non-empty. A line of N samples with no stalls spans N+`PIPE_LAT` cycles from the first read to `line_done`.
- A stall (`fifo_empty`=1) inserts a bubble: `data_valid` goes low for that slot and framing is preserved.
- `line_done` fires the cycle after the `eop` cycle.
- The earliest next `ink_i` without an abort is the cycle `line_done` is high.

## Structure
- Shared AKP package holds:
  - state enum;
  - default `CNT_W`;
  - tag struct {valid, first, last}.
- One sub-module: `akp_tag_delay`, a parameterised-depth shift register with synchronous clear. It is reusable for the PEL delay alignment.

## Test plan
- L_stroke=7, `ksi_en` 2 cycles after `ink_i`, FIFO always non-empty, PIPE_LAT=3 → 8 consecutive reads, 8 `data_valid` starting 3 cycles after the first read; `sop` on word 0, `eop` on word 7; `line_done` the next cycle.
- L_stroke=0 → single read; one `data_valid` with `sop`=`eop`=1.
- L_stroke=4, `fifo_empty` high for 2 cycles after the 2nd read → 5 reads total; a 2-cycle gap in `data_valid`; `eop` on the 5th word only.
- L_stroke=9, second `ink_i` after 4 reads → `line_abort` pulse; pending `data_valid`s suppressed; no `eop`; block in WAIT_KSI; a following `ksi_en` gives a full new line per the new `L_stroke`.
- `ksi_en` pulses in IDLE and in READ → no extra reads; `sample_cnt` unchanged by them.
- Assert `sbros_n` low mid-READ → all outputs 0 asynchronously; IDLE after release; no spurious `data_valid`.
